chord_note_dispatcher: RTL and testbench

Song-side driver for `harm_chord_player`. It walks a song ROM, decodes note entries and advance entries, and issues one-cycle `load_new_note` pulses carrying `note_to_load`, `duration` and `weight`. It deasserts `activate` while a chord is being loaded, then holds `activate` high for the advance time counted in `beat` pulses. It sits between the song ROM and `harm_chord_player` and shares `clk`, `reset` and `beat` with them.

---
 rtl/chord_note_dispatcher_if.sv | 36 +++
 rtl/chord_note_dispatcher.sv | 133 +++++++++++++
 tb/tb_chord_note_dispatcher.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chord_note_dispatcher_if.sv
// Song-side bus of the chord note dispatcher: song ROM read port plus the
// note-load and activate lines that drive harm_chord_player.
interface chord_note_dispatcher_if #(
  parameter int AW = 7
);
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [5:0]    note_to_load;
  logic [5:0]    duration;
  logic [1:0]    weight;
  logic          load_new_note;
  logic          activate;
  logic          song_done;

  modport master (
    output rom_addr,
    input  rom_data,
    output note_to_load,
    output duration,
    output weight,
    output load_new_note,
    output activate,
    output song_done
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  note_to_load,
    input  duration,
    input  weight,
    input  load_new_note,
    input  activate,
    input  song_done
  );
endinterface

// File: rtl/chord_note_dispatcher.sv
// Walks the song ROM, strobes note entries into the chord player and holds
// activate high for the beat count of each advance entry.
module chord_note_dispatcher #(
  parameter int AW = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    beat,
  chord_note_dispatcher_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_ROM   = 3'd2,
    ST_DISPATCH   = 3'd3,
    ST_GAP        = 3'd4,
    ST_WAIT_BEATS = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW-1:0] addr_r;
  logic [15:0]   entry_r;
  logic [5:0]    cnt_r;
  logic [5:0]    note_r;
  logic [5:0]    dur_r;
  logic [1:0]    weight_r;
  logic          load_r;
  logic          activate_r;
  logic          done_r;

  logic          entry_is_adv_s;
  logic [5:0]    entry_beats_s;
  logic          entry_unused_s;

  assign entry_is_adv_s = entry_r[15];
  assign entry_beats_s  = entry_r[8:3];
  assign entry_unused_s = entry_r[0];

  // Sequencer: ROM walk, entry decode, note strobe and beat countdown; play=0 freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= {AW{1'b0}};
      entry_r    <= 16'd0;
      cnt_r      <= 6'd0;
      note_r     <= 6'd0;
      dur_r      <= 6'd0;
      weight_r   <= 2'd0;
      load_r     <= 1'b0;
      activate_r <= 1'b0;
      done_r     <= 1'b0;
    end else if (play) begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_FETCH;
        end
        ST_FETCH: begin
          state_r <= ST_WAIT_ROM;
        end
        ST_WAIT_ROM: begin
          entry_r <= bus.rom_data;
          state_r <= ST_DISPATCH;
        end
        ST_DISPATCH: begin
          if (!entry_is_adv_s) begin
            note_r     <= entry_r[14:9];
            dur_r      <= entry_r[8:3];
            weight_r   <= entry_r[2:1];
            load_r     <= 1'b1;
            activate_r <= 1'b0;
            state_r    <= ST_GAP;
          end else if (entry_beats_s != 6'd0) begin
            cnt_r      <= entry_beats_s;
            activate_r <= 1'b1;
            state_r    <= ST_WAIT_BEATS;
          end else begin
            done_r     <= 1'b1;
            activate_r <= 1'b0;
            state_r    <= ST_DONE;
          end
        end
        ST_GAP: begin
          load_r <= 1'b0;
          if (addr_r == ADDR_MAX) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            addr_r  <= addr_r + ADDR_ONE;
            state_r <= ST_FETCH;
          end
        end
        ST_WAIT_BEATS: begin
          if (beat) begin
            cnt_r <= cnt_r - 6'd1;
            // The beat that empties the counter is the last one activate stays high for.
            if (cnt_r == 6'd1) begin
              activate_r <= 1'b0;
              if (addr_r == ADDR_MAX) begin
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                addr_r  <= addr_r + ADDR_ONE;
                state_r <= ST_FETCH;
              end
            end
          end
        end
        ST_DONE: begin
          activate_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Pausing masks the strobe rather than clearing it, so a due load is issued once play returns.
  assign bus.rom_addr      = addr_r;
  assign bus.note_to_load  = note_r;
  assign bus.duration      = dur_r;
  assign bus.weight        = weight_r;
  assign bus.load_new_note = load_r & play;
  assign bus.activate      = activate_r & play;
  assign bus.song_done     = done_r;

endmodule

// File: tb/tb_chord_note_dispatcher.sv
// Self-checking bench for chord_note_dispatcher: vector table, directed
// multi-cycle sequences and a randomized run against a song-level model.
module tb_chord_note_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, play, beat, play2, beat2;

  chord_note_dispatcher_if #(.AW(7)) bus_a ();
  chord_note_dispatcher_if #(.AW(3)) bus_b ();

  chord_note_dispatcher #(.AW(7)) dut_a (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .bus(bus_a.master)
  );
  chord_note_dispatcher #(.AW(3)) dut_b (
    .clk(clk), .reset(reset), .play(play2), .beat(beat2), .bus(bus_b.master)
  );

  logic [15:0] rom_a [128];
  logic [15:0] rom_b [8];

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    bus_a.rom_data <= rom_a[bus_a.rom_addr];
    bus_b.rom_data <= rom_b[bus_b.rom_addr];
  end

  int pass_cnt = 0;
  int check_cnt = 0;

  typedef struct {
    logic [15:0] word;
    logic [5:0]  note;
    logic [5:0]  dur;
    logic [1:0]  wt;
  } vec_t;

  typedef struct {
    logic [5:0] note;
    logic [5:0] dur;
    logic [1:0] wt;
    int         beats_before;
  } exp_t;

  vec_t       vecs [6];
  exp_t       exp_q [$];
  logic [5:0] chord_notes [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input logic p, input logic b);
    @(posedge clk);
    #1;
    play = p;
    beat = b;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; play = 1'b0; beat = 1'b0; play2 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, 32'(bus_a.rom_addr), 32'd0);
    check({tag, "_note"},     32'(bus_a.note_to_load), 32'd0);
    check({tag, "_dur"},      32'(bus_a.duration), 32'd0);
    check({tag, "_weight"},   32'(bus_a.weight), 32'd0);
    check({tag, "_load"},     32'(bus_a.load_new_note), 32'd0);
    check({tag, "_activate"}, 32'(bus_a.activate), 32'd0);
    check({tag, "_done"},     32'(bus_a.song_done), 32'd0);
  endtask

  task automatic wait_strobe(input int budget, output int waited);
    waited = 0;
    do begin
      step(1'b1, 1'b0);
      waited++;
    end while (!bus_a.load_new_note && waited < budget);
  endtask

  task automatic wait_activate(input int budget, output int waited);
    waited = 0;
    do begin
      step(1'b1, 1'b0);
      waited++;
    end while (!bus_a.activate && waited < budget);
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    while (!bus_a.song_done && waited < budget) begin
      step(1'b1, 1'b0);
      waited++;
    end
  endtask

  task automatic load_chord_rom();
    for (int i = 0; i < 128; i++) rom_a[i] = 16'h0000;
    rom_a[0] = 16'h4860;
    rom_a[1] = 16'h4060;
    rom_a[2] = 16'h3460;
    rom_a[3] = 16'hD427;
    rom_a[4] = 16'hFE07;
  endtask

  initial begin
    int w, nb, viol, acc, beats_acc, last, n, strobes, mism;
    logic p, b, seen_nz;
    exp_t e;

    reset = 1'b1; play = 1'b0; beat = 1'b0; play2 = 1'b0; beat2 = 1'b0;
    for (int i = 0; i < 8; i++) rom_b[i] = 16'h0000;

    vecs[0] = '{16'h4860, 6'd36, 6'd12, 2'd0};
    vecs[1] = '{16'h4060, 6'd32, 6'd12, 2'd0};
    vecs[2] = '{16'h3460, 6'd26, 6'd12, 2'd0};
    vecs[3] = '{16'h5836, 6'd44, 6'd6,  2'd3};
    vecs[4] = '{16'h7FFB, 6'd63, 6'd63, 2'd1};
    vecs[5] = '{16'h000D, 6'd0,  6'd1,  2'd2};
    chord_notes[0] = 6'd36;
    chord_notes[1] = 6'd32;
    chord_notes[2] = 6'd26;

    // Vector table: back-to-back note entries, then end marker.
    for (int i = 0; i < 128; i++) rom_a[i] = 16'h0000;
    for (int i = 0; i < 6; i++) rom_a[i] = vecs[i].word;
    rom_a[6] = 16'hFE07;
    do_reset();
    check_reset_vals("reset");
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      wait_strobe(20, w);
      check("tbl_latency", 32'(w), 32'd4);
      check("tbl_note",   32'(bus_a.note_to_load), 32'(vecs[i].note));
      check("tbl_dur",    32'(bus_a.duration), 32'(vecs[i].dur));
      check("tbl_weight", 32'(bus_a.weight), 32'(vecs[i].wt));
    end
    wait_done(20, w);
    check("tbl_done", 32'(bus_a.song_done), 32'd1);

    // Chord plus advance of 4, then end marker held.
    load_chord_rom();
    do_reset();
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_strobe(20, w);
      check("chord_spacing", 32'(w), 32'd4);
      check("chord_note", 32'(bus_a.note_to_load), 32'(chord_notes[i]));
      check("chord_dur", 32'(bus_a.duration), 32'd12);
      check("chord_act_low", 32'(bus_a.activate), 32'd0);
    end
    wait_activate(12, w);
    check("adv_act_rise", 32'(w), 32'd4);
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      if (bus_a.activate) nb++;
    end
    check("adv_beats_high", 32'(nb), 32'd4);
    step(1'b1, 1'b0);
    check("adv_act_fall", 32'(bus_a.activate), 32'd0);
    check("adv_rom_addr", 32'(bus_a.rom_addr), 32'd4);
    wait_done(12, w);
    check("end_done", 32'(bus_a.song_done), 32'd1);
    check("end_act", 32'(bus_a.activate), 32'd0);
    viol = 0;
    for (int k = 0; k < 100; k++) begin
      step(1'b1, (k % 7) == 0);
      if (bus_a.load_new_note || bus_a.activate || !bus_a.song_done) viol++;
    end
    check("end_hold", 32'(viol), 32'd0);

    // Pause inside a 5-beat advance, with 2 beats lost while paused.
    for (int i = 0; i < 128; i++) rom_a[i] = 16'h0000;
    rom_a[0] = 16'h4860;
    rom_a[1] = 16'h8028;
    rom_a[2] = 16'hFE07;
    do_reset();
    step(1'b1, 1'b0);
    wait_strobe(20, w);
    wait_activate(12, w);
    check("pause_act_rise", 32'(w), 32'd4);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, (k == 5) || (k == 12));
      if (bus_a.activate || bus_a.load_new_note) viol++;
    end
    check("pause_act_low", 32'(viol), 32'd0);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      if (!bus_a.activate) break;
      nb++;
    end
    check("pause_remaining_beats", 32'(nb), 32'd3);
    wait_done(12, w);
    check("pause_done", 32'(bus_a.song_done), 32'd1);

    // Reset in the cycle after the second strobe.
    load_chord_rom();
    do_reset();
    step(1'b1, 1'b0);
    wait_strobe(20, w);
    wait_strobe(20, w);
    check("rst_second_note", 32'(bus_a.note_to_load), 32'd32);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    wait_strobe(20, w);
    check("midrst_latency", 32'(w), 32'd4);
    check("midrst_reload", 32'(bus_a.note_to_load), 32'd36);

    // Randomized songs with random play drop-outs and beats.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 128; i++) rom_a[i] = {1'b0, 15'($urandom)};
      for (int i = 0; i < 24; i++)
        if ($urandom_range(0, 2) == 0)
          rom_a[i] = {1'b1, 6'($urandom), 6'($urandom_range(1, 4)), 3'($urandom)};
      rom_a[24] = {1'b1, 6'($urandom), 6'd0, 3'($urandom)};
      exp_q.delete();
      acc = 0;
      for (int i = 0; i < 128; i++) begin
        if (rom_a[i][15] == 1'b0) begin
          exp_q.push_back('{rom_a[i][14:9], rom_a[i][8:3], rom_a[i][2:1], acc});
          acc = 0;
        end else if (rom_a[i][8:3] == 6'd0) begin
          break;
        end else begin
          acc += int'(rom_a[i][8:3]);
        end
      end
      do_reset();
      beats_acc = 0; last = -100; viol = 0; n = 0;
      while (!bus_a.song_done && n < 4000) begin
        p = ($urandom_range(0, 7) != 0);
        b = ($urandom_range(0, 2) == 0);
        step(p, b);
        n++;
        if (bus_a.load_new_note) begin
          if (n - last < 4) viol++;
          if (bus_a.activate) viol++;
          last = n;
          check("rnd_strobe_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rnd_note", 32'(bus_a.note_to_load), 32'(e.note));
            check("rnd_dur", 32'(bus_a.duration), 32'(e.dur));
            check("rnd_weight", 32'(bus_a.weight), 32'(e.wt));
            check("rnd_beats_before", 32'(beats_acc), 32'(e.beats_before));
          end
          beats_acc = 0;
        end
        if (b && bus_a.activate) beats_acc++;
        if (!p && (bus_a.activate || bus_a.load_new_note)) viol++;
      end
      check("rnd_done", 32'(bus_a.song_done), 32'd1);
      check("rnd_notes_left", 32'(exp_q.size()), 32'd0);
      check("rnd_tail_beats", 32'(beats_acc), 32'(acc));
      check("rnd_rules", 32'(viol), 32'd0);
    end

    // AW=3 ROM full of notes: 8 strobes, then done without wrapping.
    for (int i = 0; i < 8; i++) rom_b[i] = {1'b0, 15'($urandom)};
    do_reset();
    play2 = 1'b1;
    strobes = 0; mism = 0; viol = 0; seen_nz = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step(1'b0, 1'b0);
      if (bus_b.rom_addr != 3'd0) seen_nz = 1'b1;
      else if (seen_nz) viol++;
      if (bus_b.load_new_note) begin
        if (strobes < 8) begin
          if (bus_b.note_to_load !== rom_b[strobes][14:9] ||
              bus_b.duration !== rom_b[strobes][8:3] ||
              bus_b.weight !== rom_b[strobes][2:1]) mism++;
        end
        strobes++;
      end
    end
    check("wrap_strobes", 32'(strobes), 32'd8);
    check("wrap_done", 32'(bus_b.song_done), 32'd1);
    check("wrap_rom_addr", 32'(bus_b.rom_addr), 32'd7);
    check("wrap_no_return", 32'(viol), 32'd0);
    check("wrap_data", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
